// File: rtl/pixel_splicer_pkg.sv
// Shared types and helpers for the pixel splicer: FSM state encoding,
// lane-counter sizing and the default pixel width.
package pixel_splicer_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam int DEFAULT_PIXEL_WIDTH = 24;

   // Lane counter needs at least one bit even when a beat holds a single pixel.
   function automatic int lane_w(input int ppc);
      return (ppc <= 2) ? 1 : $clog2(ppc);
   endfunction

endpackage

// File: rtl/splicer_frame_checker.sv
// Output-side frame geometry checker: counts pixels per line and lines per
// frame on the single-pixel stream and raises sticky error flags.
module splicer_frame_checker #(
   parameter int FRAME_WIDTH  = 10,
   parameter int FRAME_HEIGHT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic beat,
   input  logic sof,
   input  logic eol,
   output logic err_line,
   output logic err_frame
);

   localparam int XW = $clog2(FRAME_WIDTH + 1);
   localparam int YW = $clog2(FRAME_HEIGHT + 1);
   localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
   localparam logic [XW-1:0] X_FULL = XW'(FRAME_WIDTH);
   localparam logic [YW-1:0] Y_FULL = YW'(FRAME_HEIGHT);

   logic [XW-1:0] x_q, x_d, cur_x;
   logic [YW-1:0] y_q, y_d, cur_y;
   logic          seen_sof_q, seen_sof_d;
   logic          err_line_q, err_line_d;
   logic          err_frame_q, err_frame_d;

   always_comb begin
      cur_x       = sof ? '0 : x_q;
      cur_y       = sof ? '0 : y_q;
      x_d         = x_q;
      y_d         = y_q;
      seen_sof_d  = seen_sof_q;
      err_line_d  = err_line_q;
      err_frame_d = err_frame_q;
      if (beat) begin
         // y_q counts completed lines, so a full frame shows FRAME_HEIGHT at the next SOF.
         if (sof) begin
            seen_sof_d = 1'b1;
            if (seen_sof_q && (y_q != Y_FULL)) err_frame_d = 1'b1;
         end
         if (eol != (cur_x == X_LAST)) err_line_d = 1'b1;
         if (eol) begin
            x_d = '0;
            y_d = (cur_y == Y_FULL) ? cur_y : cur_y + YW'(1);
         end else begin
            x_d = (cur_x == X_FULL) ? cur_x : cur_x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q         <= '0;
         y_q         <= '0;
         seen_sof_q  <= 1'b0;
         err_line_q  <= 1'b0;
         err_frame_q <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         seen_sof_q  <= seen_sof_d;
         err_line_q  <= err_line_d;
         err_frame_q <= err_frame_d;
      end
   end

   assign err_line  = err_line_q;
   assign err_frame = err_frame_q;

endmodule

// File: rtl/pixel_splicer_n.sv
// AXI4-Stream splicer: PPC_IN packed pixels per input beat in, one pixel per
// beat out. Define SPLICER_FRAME_CHECK_EN to build in frame geometry checking.
module pixel_splicer_n
   import pixel_splicer_pkg::*;
#(
   parameter int PIXEL_WIDTH  = DEFAULT_PIXEL_WIDTH,
   parameter int PPC_IN       = 2,
   parameter int FRAME_WIDTH  = 10,
   parameter int FRAME_HEIGHT = 10
) (
   input  logic                          aclk,
   input  logic                          areset,
   input  logic [PIXEL_WIDTH*PPC_IN-1:0] s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tuser,
   input  logic                          s_axis_tlast,
   output logic [PIXEL_WIDTH-1:0]        m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          err_line,
   output logic                          err_frame
);

   localparam int LANE_W = lane_w(PPC_IN);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPC_IN - 1);

   state_e                          state_q, state_d;
   logic [LANE_W-1:0]               lane_q, lane_d;
   logic [PIXEL_WIDTH*PPC_IN-1:0]   held_q, held_d;
   logic                            held_user_q, held_user_d;
   logic                            held_last_q, held_last_d;
   logic                            last_lane, m_hs, s_rdy, s_hs;
   logic [PIXEL_WIDTH-1:0]          pix;

   // Handshake: a beat moves on either port only in a cycle where valid and
   // ready are both high at the rising edge; valid never waits on ready.
   always_comb begin
      last_lane   = (lane_q == LAST_LANE);
      m_hs        = (state_q == DRAIN) && m_axis_tready;
      s_rdy       = !areset && ((state_q == EMPTY) || (last_lane && m_hs));
      s_hs        = s_axis_tvalid && s_rdy;
      state_d     = state_q;
      lane_d      = lane_q;
      held_d      = held_q;
      held_user_d = held_user_q;
      held_last_d = held_last_q;
      if (s_hs) begin
         state_d     = DRAIN;
         lane_d      = '0;
         held_d      = s_axis_tdata;
         held_user_d = s_axis_tuser;
         held_last_d = s_axis_tlast;
      end else if (m_hs) begin
         if (last_lane) state_d = EMPTY;
         else           lane_d  = lane_q + LANE_W'(1);
      end
   end

   always_comb begin
      pix = '0;
      for (int i = 0; i < PPC_IN; i++) begin
         if (lane_q == LANE_W'(i)) pix = held_q[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= EMPTY;
         lane_q      <= '0;
         held_q      <= '0;
         held_user_q <= 1'b0;
         held_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         held_q      <= held_d;
         held_user_q <= held_user_d;
         held_last_q <= held_last_d;
      end
   end

   assign s_axis_tready = s_rdy;
   assign m_axis_tvalid = (state_q == DRAIN);
   assign m_axis_tdata  = pix;
   assign m_axis_tuser  = (state_q == DRAIN) && held_user_q && (lane_q == '0);
   assign m_axis_tlast  = (state_q == DRAIN) && held_last_q && last_lane;

`ifdef SPLICER_FRAME_CHECK_EN
   splicer_frame_checker #(
      .FRAME_WIDTH  (FRAME_WIDTH),
      .FRAME_HEIGHT (FRAME_HEIGHT)
   ) u_frame_checker (
      .clk       (aclk),
      .rst       (areset),
      .beat      (m_hs),
      .sof       (m_axis_tuser),
      .eol       (m_axis_tlast),
      .err_line  (err_line),
      .err_frame (err_frame)
   );
`else
   // Geometry only matters to the checker; still referenced so it stays visible.
   localparam bit GEOM_OK = (FRAME_WIDTH > 0) && (FRAME_HEIGHT > 0);
   assign err_line  = 1'b0 & GEOM_OK;
   assign err_frame = 1'b0 & GEOM_OK;
`endif

endmodule

// File: tb/tb_pixel_splicer_n.sv
// Directed bench for pixel_splicer_n: 2-PPC/24-bit main instance plus
// 4-PPC and 1-PPC 8-bit instances.
module tb_pixel_splicer_n;

   localparam int PW  = 24;
   localparam int PPC = 2;
`ifdef SPLICER_FRAME_CHECK_EN
   localparam bit FC = 1'b1;
`else
   localparam bit FC = 1'b0;
`endif

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   logic [PW*PPC-1:0] s_data;
   logic              s_valid, s_ready, s_user, s_last;
   logic [PW-1:0]     m_data;
   logic              m_valid, m_ready, m_user, m_last;
   logic              err_line, err_frame;

   logic [31:0] s4_data;
   logic        s4_valid, s4_ready, s4_user, s4_last;
   logic [7:0]  m4_data;
   logic        m4_valid, m4_ready, m4_user, m4_last, e4_line, e4_frame;

   logic [7:0]  s1_data;
   logic        s1_valid, s1_ready, s1_user, s1_last;
   logic [7:0]  m1_data;
   logic        m1_valid, m1_ready, m1_user, m1_last, e1_line, e1_frame;

   pixel_splicer_n #(.PIXEL_WIDTH(PW), .PPC_IN(PPC), .FRAME_WIDTH(10), .FRAME_HEIGHT(10)) dut (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
      .s_axis_tuser(s_user), .s_axis_tlast(s_last),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
      .m_axis_tuser(m_user), .m_axis_tlast(m_last),
      .err_line(err_line), .err_frame(err_frame));

   pixel_splicer_n #(.PIXEL_WIDTH(8), .PPC_IN(4), .FRAME_WIDTH(10), .FRAME_HEIGHT(10)) dut4 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s4_data), .s_axis_tvalid(s4_valid), .s_axis_tready(s4_ready),
      .s_axis_tuser(s4_user), .s_axis_tlast(s4_last),
      .m_axis_tdata(m4_data), .m_axis_tvalid(m4_valid), .m_axis_tready(m4_ready),
      .m_axis_tuser(m4_user), .m_axis_tlast(m4_last),
      .err_line(e4_line), .err_frame(e4_frame));

   pixel_splicer_n #(.PIXEL_WIDTH(8), .PPC_IN(1), .FRAME_WIDTH(10), .FRAME_HEIGHT(10)) dut1 (
      .aclk(aclk), .areset(areset),
      .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
      .s_axis_tuser(s1_user), .s_axis_tlast(s1_last),
      .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
      .m_axis_tuser(m1_user), .m_axis_tlast(m1_last),
      .err_line(e1_line), .err_frame(e1_frame));

   int n_checks = 0;
   int n_fail   = 0;

   logic [PW*PPC-1:0] src_data [64];
   logic              src_user [64];
   logic              src_last [64];
   logic [PW-1:0]     cap_data [$];
   logic              cap_user [$];
   logic              cap_last [$];
   logic [PW-1:0]     exp_q    [$];
   int                first_acc, first_out, last_out, s_ready_lo, stall_err;
   bit                timed_out;

   // Driver/monitor for the main instance: feeds src_* beats, records output pixels.
   task automatic drive_main(input int nbeats, input int npix, input bit rand_ready, input int max_cyc);
      int bi = 0;
      int cyc = 0;
      bit stalled = 0;
      logic [PW-1:0] stall_pix = '0;
      cap_data.delete(); cap_user.delete(); cap_last.delete();
      first_acc = -1; first_out = -1; last_out = -1; s_ready_lo = 0; stall_err = 0;
      while (cap_data.size() < npix && cyc < max_cyc) begin
         @(negedge aclk);
         s_valid = (bi < nbeats);
         if (bi < nbeats) begin
            s_data = src_data[bi]; s_user = src_user[bi]; s_last = src_last[bi];
         end
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (stalled && (m_valid !== 1'b1 || m_data !== stall_pix)) stall_err++;
         if (m_valid && !s_ready) s_ready_lo++;
         if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = cyc;
            bi++;
         end
         if (m_valid && m_ready) begin
            cap_data.push_back(m_data); cap_user.push_back(m_user); cap_last.push_back(m_last);
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            stalled = 0;
         end else begin
            stalled   = m_valid;
            stall_pix = m_data;
         end
         cyc++;
      end
      timed_out = (cap_data.size() < npix);
   endtask

   task automatic test_reset;
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      #1;
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
      n_checks++;
      if ({m_valid, m_user, m_last} !== 3'b000 || m_data !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got valid=%b user=%b last=%b data=%h want all 0", m_valid, m_user, m_last, m_data);
      end
      n_checks++;
      if ({err_line, err_frame} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b%b want 00", err_line, err_frame); end
      @(negedge aclk);
      areset = 1'b0;
      #1;
      n_checks++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b want 1", s_ready); end
   endtask

   task automatic test_sof_beat;
      src_data[0] = 48'h222222_111111; src_user[0] = 1'b1; src_last[0] = 1'b0;
      drive_main(1, 2, 1'b0, 10);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL sof_timeout: got %0d pixels want 2", cap_data.size()); end
      n_checks++;
      if (cap_data[0] !== 24'h111111 || cap_user[0] !== 1'b1 || cap_last[0] !== 1'b0) begin
         n_fail++; $display("FAIL sof_pix0: got %h u%b l%b want 111111 u1 l0", cap_data[0], cap_user[0], cap_last[0]);
      end
      n_checks++;
      if (cap_data[1] !== 24'h222222 || cap_user[1] !== 1'b0 || cap_last[1] !== 1'b0) begin
         n_fail++; $display("FAIL sof_pix1: got %h u%b l%b want 222222 u0 l0", cap_data[1], cap_user[1], cap_last[1]);
      end
      n_checks++;
      if (first_out - first_acc !== 1) begin n_fail++; $display("FAIL sof_latency: got %0d want 1", first_out - first_acc); end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < 5; k++) begin
         src_data[k] = {24'h0A0000 + 24'(2*k+1), 24'h0A0000 + 24'(2*k)};
         src_user[k] = (k == 0);
         src_last[k] = (k == 4);
      end
      drive_main(5, 10, 1'b0, 30);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL b2b_timeout: got %0d pixels want 10", cap_data.size()); end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (cap_data[i] !== 24'h0A0000 + 24'(i) || cap_last[i] !== 1'(i == 9) || cap_user[i] !== 1'(i == 0)) begin
            n_fail++;
            $display("FAIL b2b_pix%0d: got %h u%b l%b want %h u%b l%b", i, cap_data[i], cap_user[i], cap_last[i],
                     24'h0A0000 + 24'(i), i == 0, i == 9);
         end
      end
      n_checks++;
      if (last_out - first_out !== 9) begin n_fail++; $display("FAIL b2b_span: got %0d cycles want 9", last_out - first_out); end
      n_checks++;
      if (s_ready_lo !== 5) begin n_fail++; $display("FAIL b2b_s_ready_low: got %0d want 5", s_ready_lo); end
   endtask

   task automatic test_backpressure;
      exp_q.delete();
      for (int k = 0; k < 6; k++) begin
         src_data[k] = {24'($urandom), 24'($urandom)};
         src_user[k] = (k == 0);
         src_last[k] = (k == 5);
         exp_q.push_back(src_data[k][23:0]);
         exp_q.push_back(src_data[k][47:24]);
      end
      drive_main(6, 12, 1'b1, 200);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got %0d pixels want 12", cap_data.size()); end
      n_checks++;
      if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (cap_data[i] !== exp_q[i] || cap_last[i] !== 1'(i == 11)) begin
            n_fail++; $display("FAIL bp_pix%0d: got %h l%b want %h l%b", i, cap_data[i], cap_last[i], exp_q[i], i == 11);
         end
      end
   endtask

   task automatic test_reset_mid_drain;
      int extra = 0;
      @(negedge aclk);
      s_valid = 1'b1; s_data = 48'hBBBBBB_AAAAAA; s_user = 1'b0; s_last = 1'b1; m_ready = 1'b1;
      @(negedge aclk);
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 24'hAAAAAA) begin
         n_fail++; $display("FAIL mid_lane0: got v%b %h want v1 aaaaaa", m_valid, m_data);
      end
      @(negedge aclk);
      areset = 1'b1;
      #1;
      n_checks++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_s_ready: got %b want 0", s_ready); end
      @(negedge aclk);
      #1;
      n_checks++;
      if ({m_valid, m_user, m_last} !== 3'b000 || m_data !== '0) begin
         n_fail++; $display("FAIL mid_outputs: got v%b u%b l%b %h want all 0", m_valid, m_user, m_last, m_data);
      end
      areset = 1'b0;
      repeat (4) begin
         @(negedge aclk);
         #1;
         if (m_valid) extra++;
      end
      n_checks++;
      if (extra !== 0) begin n_fail++; $display("FAIL mid_no_lane1: got %0d valid cycles want 0", extra); end
   endtask

   task automatic test_ppc4;
      logic [7:0] exp4 [4];
      int got = 0;
      exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
      @(negedge aclk);
      s4_valid = 1'b1; s4_data = 32'h44332211; s4_user = 1'b1; s4_last = 1'b1; m4_ready = 1'b1;
      for (int c = 0; c < 8 && got < 4; c++) begin
         @(negedge aclk);
         s4_valid = 1'b0;
         #1;
         if (m4_valid) begin
            n_checks++;
            if (m4_data !== exp4[got] || m4_user !== 1'(got == 0) || m4_last !== 1'(got == 3) || c !== got) begin
               n_fail++;
               $display("FAIL ppc4_pix%0d: got %h u%b l%b cyc%0d want %h u%b l%b cyc%0d", got, m4_data, m4_user, m4_last,
                        c, exp4[got], got == 0, got == 3, got);
            end
            got++;
         end
      end
      n_checks++;
      if (got !== 4) begin n_fail++; $display("FAIL ppc4_count: got %0d want 4", got); end
   endtask

   task automatic test_ppc1;
      logic [7:0] d1 [4];
      d1[0] = 8'hA1; d1[1] = 8'hB2; d1[2] = 8'hC3; d1[3] = 8'hD4;
      for (int c = 0; c < 6; c++) begin
         @(negedge aclk);
         s1_valid = (c < 4);
         s1_data  = (c < 4) ? d1[c] : 8'h00;
         s1_user  = (c == 0);
         s1_last  = (c == 3);
         m1_ready = 1'b1;
         #1;
         if (c < 4) begin
            n_checks++;
            if (s1_ready !== 1'b1) begin n_fail++; $display("FAIL ppc1_ready%0d: got %b want 1", c, s1_ready); end
         end
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (m1_valid !== 1'b1 || m1_data !== d1[c-1] || m1_last !== 1'(c == 4) || m1_user !== 1'(c == 1)) begin
               n_fail++;
               $display("FAIL ppc1_pix%0d: got v%b %h u%b l%b want v1 %h u%b l%b", c - 1, m1_valid, m1_data, m1_user,
                        m1_last, d1[c-1], c == 1, c == 4);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (m1_valid !== 1'b0) begin n_fail++; $display("FAIL ppc1_idle: got %b want 0", m1_valid); end
         end
      end
   endtask

   task automatic test_frame_check;
      @(negedge aclk); areset = 1'b1;
      @(negedge aclk); areset = 1'b0;
      for (int k = 0; k < 50; k++) begin
         src_data[k % 64] = {24'(2*k+1), 24'(2*k)};
         src_user[k % 64] = (k == 0);
         src_last[k % 64] = (k % 5 == 4);
      end
      drive_main(50, 100, 1'b0, 400);
      @(negedge aclk); #1;
      n_checks++;
      if (timed_out || {err_line, err_frame} !== 2'b00) begin
         n_fail++; $display("FAIL fc_good_frame: got err=%b%b timeout=%b want 00 0", err_line, err_frame, timed_out);
      end
      for (int k = 0; k < 4; k++) begin
         src_user[k] = (k == 0);
         src_last[k] = (k == 3);
      end
      drive_main(4, 8, 1'b0, 40);
      @(negedge aclk); #1;
      n_checks++;
      if (err_line !== FC || err_frame !== 1'b0) begin
         n_fail++; $display("FAIL fc_short_line: got err_line=%b err_frame=%b want %b 0", err_line, err_frame, FC);
      end
      src_user[0] = 1'b1; src_last[0] = 1'b0;
      drive_main(1, 2, 1'b0, 10);
      @(negedge aclk); #1;
      n_checks++;
      if (err_frame !== FC || err_line !== FC) begin
         n_fail++; $display("FAIL fc_short_frame: got err_line=%b err_frame=%b want %b %b", err_line, err_frame, FC, FC);
      end
   endtask

   initial begin
      s_valid = 0; s_data = '0; s_user = 0; s_last = 0; m_ready = 0;
      s4_valid = 0; s4_data = '0; s4_user = 0; s4_last = 0; m4_ready = 0;
      s1_valid = 0; s1_data = '0; s1_user = 0; s1_last = 0; m1_ready = 0;
      test_reset();
      test_sof_beat();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_drain();
      test_ppc4();
      test_ppc1();
      test_frame_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pixel_splicer_n.md
# pixel_splicer_n

Parametrised AXI4-Stream video splicer: accepts beats carrying PPC_IN packed pixels and emits one pixel per beat, preserving SOF (tuser) and EOL (tlast) framing. Sits between a multi-pixel-per-clock video source (e.g. 2-PPC capture) and single-pixel processing stages. Generalises the fixed 2-pixel splicer to any PPC_IN, adds full backpressure support and optional frame-geometry checking.

## Interface
- PIXEL_WIDTH, 24, bits per pixel
- PPC_IN, 2, pixels per input beat (≥1); input width = PIXEL_WIDTH*PPC_IN
- FRAME_WIDTH, 10, active pixels per line
- FRAME_HEIGHT, 10, lines per frame
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_axis_tdata  in  PIXEL_WIDTH*PPC_IN  packed pixels, pixel 0 in LSBs
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input beat accepted when tvalid&tready
- s_axis_tuser  in  1  SOF, meaningful on first beat of frame
- s_axis_tlast  in  1  EOL, meaningful on last beat of line
- m_axis_tdata  out  PIXEL_WIDTH  one pixel
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tuser  out  1  SOF, on pixel 0 of SOF beat only
- m_axis_tlast  out  1  EOL, on pixel PPC_IN-1 of EOL beat only
- err_line  out  1  sticky: line length ≠ FRAME_WIDTH (frame-check build only)
- err_frame  out  1  sticky: line count ≠ FRAME_HEIGHT at SOF (frame-check build only)

## Operation
- Holding register stores one accepted beat plus its tuser/tlast; lane counter lane ∈ [0, PPC_IN-1].
- States: EMPTY (no beat held), DRAIN (beat held, presenting lane).
- EMPTY: s_axis_tready=1; on accept → DRAIN, lane=0.
- DRAIN: m_axis_tvalid=1, m_axis_tdata = held[lane]. On m handshake: lane<PPC_IN-1 → lane+1; lane=PPC_IN-1 → if s_axis_tvalid accept next beat (stay DRAIN, lane=0) else → EMPTY.
- s_axis_tready = EMPTY | (DRAIN & lane==PPC_IN-1 & m_axis_tready); no input bubble between beats.
- m_axis_tuser = held_tuser & lane==0; m_axis_tlast = held_tlast & lane==PPC_IN-1.
- Output stable while m_axis_tvalid & !m_axis_tready.
- PPC_IN=1: degenerates to a one-deep register slice, full throughput.
- Lane counter width $clog2(PPC_IN) (min 1 bit); no wrap beyond PPC_IN-1.

## Timing
- Reset (areset=1 at edge): state EMPTY, lane 0, m_axis_tvalid/tuser/tlast 0, m_axis_tdata 0, err_* 0; s_axis_tready forced 0 while areset high.
- Latency: first output pixel valid the cycle after input accept.
- Throughput: one input beat per PPC_IN cycles with m_axis_tready held high; output 100 % utilised given steady input.
- Reset mid-DRAIN: held beat discarded, no partial pixels emitted after reset.
- Simultaneous last-lane output handshake and input accept: new beat loaded, lane=0, m_axis_tvalid stays 1.

## Configuration
- SPLICER_FRAME_CHECK_EN defined: output-side pixel counter x and line counter y. m_axis_tuser at x=0,y=0 ... tuser resyncs counters to 0. err_line set when output tlast and x≠FRAME_WIDTH-1, or x reaches FRAME_WIDTH-1 without tlast. err_frame set when tuser arrives and y≠FRAME_HEIGHT (ignored for first frame after reset). Errors cleared only by areset. Data/framing pass unchanged.
- Not defined: no counters; err_line, err_frame tied 0.

## Structure
- Package pixel_splicer_pkg: state enum (EMPTY, DRAIN), function for lane-counter width, default PIXEL_WIDTH constant.
- Optional sub-module splicer_frame_checker (counters + sticky flags), instantiated only under SPLICER_FRAME_CHECK_EN.

## Test plan
- PPC_IN=2: send 0x222222_111111 tuser=1 → out 0x111111 tuser=1, then 0x222222 tuser=0, latency 1 cycle.
- 5 beats, last tlast=1, m_axis_tready=1 → 10 pixels back-to-back, tlast only on 10th; s_axis_tready low every other cycle.
- m_axis_tready toggled 1/0 randomly → output data sequence identical, data stable while stalled, no drop/duplicate.
- areset pulsed after lane 0 handshake → no lane 1 pixel emitted, all outputs 0, s_axis_tready 0 during reset.
- PPC_IN=4: beat 0x44_33_22_11 (PIXEL_WIDTH=8) → 0x11,0x22,0x33,0x44 in order; PPC_IN=1 → full-rate passthrough.
- SPLICER_FRAME_CHECK_EN, FRAME_WIDTH=10: line of 4 beats (8 pixels) with tlast → err_line=1 after 8th pixel; 10×10 correct frame → both errors 0.
